// File: rtl/serial_adder_8bit.sv
// Bit-serial 8-bit adder: one full-adder stage per cycle, LSB first.
// Optional macro ADDER_SATURATE_EN clamps S to 8'hFF on final carry-out.
module serial_adder_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic       busy,
  output logic       done,
  output logic [7:0] S,
  output logic       Cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  acc_q, acc_d;
  logic [7:0]  s_q, s_d;
  logic        cout_q, cout_d;

  logic        sum_bit;
  logic        carry_bit;
  logic [7:0]  full_sum;

  // Single full-adder stage on the current LSBs of the shift registers.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
    carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    full_sum  = {sum_bit, acc_q};
  end

  // Next-state, datapath updates and result capture on the bit-7 cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          cnt_d   = 3'd0;
          acc_d   = 7'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[7:1]};
        b_d   = {1'b0, b_q[7:1]};
        c_d   = carry_bit;
        acc_d = full_sum[7:1];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          cout_d  = carry_bit;
`ifdef ADDER_SATURATE_EN
          s_d     = carry_bit ? 8'hFF : full_sum;
`else
          s_d     = full_sum;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      c_q     <= 1'b0;
      cnt_q   <= 3'd0;
      acc_q   <= 7'd0;
      s_q     <= 8'd0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: doc/serial_adder_8bit.md
SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to add; sampled on rising edge of clk.
REQ-005 A  input  8  addend A; captured in the cycle start is accepted.
REQ-006 B  input  8  addend B; captured in the cycle start is accepted.
REQ-007 Cin  input  1  carry-in; captured in the cycle start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  single-cycle pulse marking S and Cout valid.
REQ-010 S  output  8  sum.
REQ-011 Cout  output  1  carry-out of bit 7.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE.
REQ-014 On acceptance, A, B and Cin SHALL be copied into internal shift and carry registers, the bit counter SHALL clear to 0, and the state SHALL go to RUN.
REQ-015 In RUN, one full-adder stage SHALL process operand bit k per cycle, for k=0..7 in order LSB first.
REQ-016 Each RUN cycle SHALL shift the sum bit into the result register and store the carry for bit k+1.
REQ-017 After the cycle that processes bit 7, the state SHALL go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly that cycle and busy SHALL be 0.
REQ-019 Latency: start accepted at edge t SHALL give done=1 in the cycle following edge t+8, i.e. 8 RUN cycles then 1 DONE cycle.
REQ-020 From DONE, the state SHALL go to RUN if start=1, otherwise to IDLE; back-to-back operations SHALL add no idle cycle.
REQ-021 start asserted during RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-022 S and Cout SHALL hold their last valid values from DONE until the next DONE.
REQ-023 S and Cout SHALL NOT be visibly altered during RUN; partial results SHALL be kept internal.
REQ-024 Arithmetic: {Cout,S} SHALL equal A + B + Cin, computed modulo 512; there is no signed interpretation.
REQ-025 The bit counter SHALL be 3 bits and SHALL wrap from 7 to 0 only on leaving RUN.
REQ-026 busy SHALL be 1 exactly in RUN.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, S=8'h00, Cout=0, and counter, carry and shift registers all 0.
REQ-028 Reset SHALL take priority over start and SHALL abort any in-progress addition.
REQ-029 An aborted addition SHALL produce no done pulse.
REQ-030 The first start after rst_n returns to 1 SHALL be accepted normally.

Configuration
REQ-031 Macro ADDER_SATURATE_EN SHALL select saturating behaviour.
REQ-032 With ADDER_SATURATE_EN defined: when the final carry is 1, S SHALL be presented as 8'hFF and Cout SHALL still report 1.
REQ-033 Without ADDER_SATURATE_EN: S SHALL be the raw low 8 bits of the sum, with wrap-around.
REQ-034 Latency and handshake SHALL be identical with and without ADDER_SATURATE_EN.

Verification
REQ-035 A=8'h3C, B=8'h05, Cin=0, start for 1 cycle -> busy high for 8 cycles, then done=1 with S=8'h41, Cout=0, 9 cycles after acceptance.
REQ-036 A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1; with ADDER_SATURATE_EN -> S=8'hFF, Cout=1.
REQ-037 A=8'h80, B=8'h7F, Cin=1 -> S=8'h00, Cout=1; A=8'h00, B=8'h00, Cin=0 -> S=8'h00, Cout=0.
REQ-038 Second start pulse with A=B=8'hAA issued in RUN cycle 4 -> ignored; result is that of the first operands only.
REQ-039 start held high continuously with operand sequence 1+1, 2+2 -> done pulses exactly 9 cycles apart with S=8'h02, then S=8'h04.
REQ-040 rst_n=0 in RUN cycle 5 -> next cycle busy=0, done=0, S=8'h00, Cout=0; no done pulse follows.
